// File: rtl/s2p_pkg.sv
// rtl/s2p_pkg.sv - width helpers and frame-length clamping for serial_to_parallel_framed.
package s2p_pkg;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int ptr_w(input int width);
        return $clog2(width);
    endfunction

    // A zero or oversized length means "use the full frame width".
    function automatic int clamp_len(input int len, input int width);
        if (len == 0 || len > width)
            return width;
        return len;
    endfunction

endpackage

// File: rtl/s2p_fill_stage.sv
// rtl/s2p_fill_stage.sv - fill pointer, length capture, lane write and close detection.
// Lane order selected by SERIAL_TO_PARALLEL_MSB_FIRST_EN (undefined: element k in lane k).
module s2p_fill_stage
    import s2p_pkg::*;
#(
    parameter int               XLEN      = 8,
    parameter int               WIDTH     = 16,
    parameter logic [XLEN-1:0]  PAD_VALUE = '0,
    localparam int              CNT_W     = cnt_w(WIDTH),
    localparam int              PTR_W     = ptr_w(WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         beat,
    input  logic [XLEN-1:0]              data,
    input  logic                         last,
    input  logic [CNT_W-1:0]             cfg_len,
    output logic [WIDTH-1:0][XLEN-1:0]   frame,
    output logic [CNT_W-1:0]             count,
    output logic                         close
);

    logic [WIDTH-1:0][XLEN-1:0] lanes_q;
    logic [PTR_W-1:0]           ptr_q;
    logic [CNT_W-1:0]           len_q;
    logic [CNT_W-1:0]           len_eff;
    logic [CNT_W-1:0]           cnt_now;
    logic [PTR_W-1:0]           lane_idx;

    // On the first beat the fresh cfg_len decides closing, so a length of 1 closes immediately.
    always_comb begin
        len_eff = (ptr_q == '0) ? CNT_W'(clamp_len(int'(cfg_len), WIDTH)) : len_q;
        cnt_now = CNT_W'(ptr_q) + CNT_W'(1);
        close   = beat && ((cnt_now == len_eff) || last);
        count   = cnt_now;
`ifdef SERIAL_TO_PARALLEL_MSB_FIRST_EN
        lane_idx = PTR_W'(WIDTH - 1) - ptr_q;
`else
        lane_idx = ptr_q;
`endif
        frame           = lanes_q;
        frame[lane_idx] = data;
    end

    // Lanes are re-padded on every close, so unfilled lanes of the next frame never hold stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            len_q   <= CNT_W'(WIDTH);
            lanes_q <= {WIDTH{PAD_VALUE}};
        end else if (beat) begin
            if (ptr_q == '0)
                len_q <= len_eff;
            if (close) begin
                ptr_q   <= '0;
                lanes_q <= {WIDTH{PAD_VALUE}};
            end else begin
                ptr_q             <= ptr_q + PTR_W'(1);
                lanes_q[lane_idx] <= data;
            end
        end
    end

endmodule

// File: rtl/serial_to_parallel_framed.sv
// rtl/serial_to_parallel_framed.sv - framed serial-to-parallel converter with double buffering.
// Optional SERIAL_TO_PARALLEL_MSB_FIRST_EN places element k in lane WIDTH-1-k.
module serial_to_parallel_framed
    import s2p_pkg::*;
#(
    parameter int               XLEN      = 8,
    parameter int               WIDTH     = 16,
    parameter logic [XLEN-1:0]  PAD_VALUE = '0,
    localparam int              CNT_W     = cnt_w(WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [XLEN-1:0]              s_data,
    input  logic                         s_last,
    input  logic [CNT_W-1:0]             cfg_len,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [WIDTH-1:0][XLEN-1:0]   m_data,
    output logic [CNT_W-1:0]             m_count
);

    logic                       beat;
    logic                       m_fire;
    logic [WIDTH-1:0][XLEN-1:0] fill_frame;
    logic [CNT_W-1:0]           fill_count;
    logic                       fill_close;
    logic                       fill_full;
    logic [WIDTH-1:0][XLEN-1:0] hold_data;
    logic [CNT_W-1:0]           hold_count;

    // fill_full is a flop, so s_ready has no combinational path from m_ready.
    assign s_ready = ~fill_full;
    assign beat    = s_valid & s_ready;
    assign m_fire  = m_valid & m_ready;

    s2p_fill_stage #(
        .XLEN      (XLEN),
        .WIDTH     (WIDTH),
        .PAD_VALUE (PAD_VALUE)
    ) u_fill (
        .clk     (clk),
        .rst     (rst),
        .beat    (beat),
        .data    (s_data),
        .last    (s_last),
        .cfg_len (cfg_len),
        .frame   (fill_frame),
        .count   (fill_count),
        .close   (fill_close)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid    <= 1'b0;
            m_count    <= '0;
            m_data     <= {WIDTH{PAD_VALUE}};
            fill_full  <= 1'b0;
            hold_data  <= {WIDTH{PAD_VALUE}};
            hold_count <= '0;
        end else if (fill_close) begin
            if (!m_valid || m_fire) begin
                m_valid <= 1'b1;
                m_data  <= fill_frame;
                m_count <= fill_count;
            end else begin
                hold_data  <= fill_frame;
                hold_count <= fill_count;
                fill_full  <= 1'b1;
            end
        end else if (fill_full && m_fire) begin
            m_data    <= hold_data;
            m_count   <= hold_count;
            fill_full <= 1'b0;
        end else if (m_fire) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_to_parallel_framed.sv
// tb/tb_serial_to_parallel_framed.sv - scoreboard bench for serial_to_parallel_framed.
module tb_serial_to_parallel_framed;

    localparam int XLEN  = 8;
    localparam int WIDTH = 16;
    localparam int CNT_W = 5;
    localparam logic [XLEN-1:0] PAD = 8'hEE;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       s_valid = 1'b0;
    logic                       s_ready;
    logic [XLEN-1:0]            s_data = '0;
    logic                       s_last = 1'b0;
    logic [CNT_W-1:0]           cfg_len = '0;
    logic                       m_valid;
    logic                       m_ready = 1'b0;
    logic [WIDTH-1:0][XLEN-1:0] m_data;
    logic [CNT_W-1:0]           m_count;

    typedef struct {
        logic [WIDTH*XLEN-1:0] data;
        logic [CNT_W-1:0]      count;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   ready_wait = 0;

    serial_to_parallel_framed #(
        .XLEN      (XLEN),
        .WIDTH     (WIDTH),
        .PAD_VALUE (PAD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .cfg_len (cfg_len),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_count (m_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] mk(input int base, input int n);
        logic [WIDTH-1:0][XLEN-1:0] f;
        for (int k = 0; k < WIDTH; k++) f[k] = PAD;
        for (int k = 0; k < n; k++) begin
`ifdef SERIAL_TO_PARALLEL_MSB_FIRST_EN
            f[WIDTH-1-k] = 8'(base + k);
`else
            f[k] = 8'(base + k);
`endif
        end
        return f;
    endfunction

    task automatic push_frame(input int base, input int n);
        exp_t e;
        e.data  = mk(base, n);
        e.count = CNT_W'(n);
        exp_q.push_back(e);
    endtask

    task automatic send(input int v, input logic last);
        int  n = 0;
        logic ok = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'(v);
        s_last  = last;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = s_ready;
            if (!ok) ready_wait++;
            @(posedge clk);
            #1;
            n++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (!ok) chk("send_timeout", 128'(v), 128'hFFFF);
    endtask

    task automatic send_run(input int base, input int n, input logic last);
        for (int i = 0; i < n; i++) send(base + i, last && (i == n - 1));
    endtask

    task automatic drain();
        m_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", 128'(exp_q.size()), 128'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pops on every output handshake and checks stability while stalled.
    logic                  prev_stall = 1'b0;
    logic [WIDTH*XLEN-1:0] prev_data;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 128'(m_valid), 128'd1);
                chk("stall_data", m_data, prev_data);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", m_data, 128'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("m_data", m_data, e.data);
                    chk("m_count", 128'(m_count), 128'(e.count));
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_m_valid", 128'(m_valid), 128'd0);
        chk("reset_s_ready", 128'(s_ready), 128'd1);
        chk("reset_m_count", 128'(m_count), 128'd0);
        chk("reset_m_data", m_data, mk(0, 0));

        // Two full frames streamed back to back.
        cfg_len = 0;
        m_ready = 1'b1;
        ready_wait = 0;
        push_frame(8'h00, 16);
        push_frame(8'h10, 16);
        send_run(8'h00, 15, 1'b0);
        chk("lat1_before", 128'(m_valid), 128'd0);
        send(8'h0F, 1'b0);
        chk("lat1_valid", 128'(m_valid), 128'd1);
        send_run(8'h10, 15, 1'b0);
        chk("lat2_before", 128'(m_valid), 128'd0);
        send(8'h1F, 1'b0);
        chk("lat2_valid", 128'(m_valid), 128'd1);
        chk("stream_no_stall", 128'(ready_wait), 128'd0);
        drain();

        // Short configured length, padding.
        cfg_len = 4;
        push_frame(1, 4);
        send_run(1, 4, 1'b0);
        drain();

        // Early close by s_last, then restart at lane 0.
        cfg_len = 16;
        push_frame(8'h0A, 3);
        send_run(8'h0A, 3, 1'b1);
        cfg_len = 2;
        push_frame(8'h20, 2);
        send_run(8'h20, 2, 1'b0);
        drain();

        // s_last on the len-th beat closes once; s_last on the first beat gives count 1.
        cfg_len = 4;
        push_frame(8'h70, 4);
        send_run(8'h70, 4, 1'b1);
        push_frame(8'h74, 1);
        send(8'h74, 1'b1);
        // Oversized length clamps to WIDTH.
        cfg_len = 31;
        push_frame(8'hB0, 16);
        send_run(8'hB0, 16, 1'b0);
        drain();

        // Backpressure: 40 elements with the consumer stalled.
        cfg_len = 16;
        m_ready = 1'b0;
        push_frame(8'h40, 16);
        push_frame(8'h50, 16);
        push_frame(8'h60, 8);
        send_run(8'h40, 31, 1'b0);
        chk("bp_ready_before", 128'(s_ready), 128'd1);
        send(8'h5F, 1'b0);
        chk("bp_ready_drop", 128'(s_ready), 128'd0);
        s_valid = 1'b1;
        s_data  = 8'h60;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("bp_hold_ready", 128'(s_ready), 128'd0);
            chk("bp_hold_data", m_data, mk(8'h40, 16));
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        chk("bp_f2_valid", 128'(m_valid), 128'd1);
        chk("bp_f2_data", m_data, mk(8'h50, 16));
        chk("bp_ready_back", 128'(s_ready), 128'd1);
        send_run(8'h60, 8, 1'b1);
        drain();

        // Reset with a partial frame and a pending output frame.
        m_ready = 1'b0;
        cfg_len = 16;
        send_run(8'h80, 16, 1'b0);
        send_run(8'h90, 7, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst2_m_valid", 128'(m_valid), 128'd0);
        chk("rst2_s_ready", 128'(s_ready), 128'd1);
        m_ready = 1'b1;
        push_frame(8'hA0, 3);
        send_run(8'hA0, 3, 1'b1);
        drain();

        // cfg_len change mid-frame is ignored until the next frame.
        cfg_len = 8;
        push_frame(8'h30, 8);
        push_frame(8'h38, 2);
        send(8'h30, 1'b0);
        cfg_len = 2;
        send_run(8'h31, 7, 1'b0);
        send_run(8'h38, 2, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
